spi_pwm_bank: RTL

Parametrised SPI-controlled PWM generator: CHANNELS independent outputs sharing one free-running period counter of WIDTH bits. A mode-0 SPI slave, oversampled by the system clock, gives read/write access to per-channel duty registers, a programmable period, and a control register. Duty and period writes are double-buffered and take effect only at the period boundary, so outputs never glitch mid-period. Sits at the chip pin boundary: SPI pins from the host MCU, pwm_out to LED/servo drivers.

---
 rtl/spi_pwm_bank.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_pwm_bank.sv
// SPI-controlled PWM bank: CHANNELS outputs share one period counter.
// A mode-0 SPI slave, oversampled by clk, accesses double-buffered duty and
// period registers plus an unbuffered control register.

// One PWM channel: shadow/active duty pair and the registered output.
module spi_pwm_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wrap,
    input  logic [WIDTH-1:0] cnt,
    input  logic             enable,
    input  logic             invert,
    output logic [WIDTH-1:0] duty_sh,
    output logic             pwm
);
    logic [WIDTH-1:0] duty_act;

    // Shadow loads from SPI; active copies the old shadow at the period boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wrap)  duty_act <= duty_sh;
            if (wr_en) duty_sh  <= wr_data;
            pwm <= enable ? ((cnt < duty_act) ^ invert) : invert;
        end
    end
endmodule

module spi_pwm_bank #(
    parameter int CHANNELS = 7,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int FW = 8 + WIDTH;          // frame length in bits
    localparam int SW = FW - 1;             // shift register keeps all but the last bit
    localparam int CW = $clog2(FW + 1);
    localparam logic [6:0] ADDR_TOP  = 7'h7E;
    localparam logic [6:0] ADDR_CTRL = 7'h7F;
    localparam logic [WIDTH-1:0] TOP_RST = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic             en;
        logic [6:0]       addr;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev;
    logic [CW-1:0]    bit_cnt;
    logic [SW-1:0]    shreg;
    logic [WIDTH-1:0] rd_shift, rd_data;
    logic [WIDTH-1:0] cnt, top_act, top_sh;
    logic [1:0]       ctrl;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_sh;
    wr_req_t wr;

    wire sclk_rise = sclk_sync[1] & ~sclk_prev;
    wire sclk_fall = ~sclk_sync[1] & sclk_prev;
    wire cs_active = ~cs_sync[1];
    wire wrap      = (cnt == top_act);

    // Two-flop synchronisers on all SPI pins plus the sclk edge-detect flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    // Write request fires on the rise that completes a write frame.
    always_comb begin
        wr.en   = cs_active & sclk_rise & (bit_cnt == CW'(FW - 1)) & shreg[SW-1];
        wr.addr = shreg[WIDTH+5:WIDTH-1];
        wr.data = {shreg[WIDTH-2:0], mosi_sync[1]};
    end

    // Read-back mux addressed by the 7 address bits once the header is in.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (shreg[6:0] == 7'(i)) rd_data = duty_sh[i];
        if (shreg[6:0] == ADDR_TOP)  rd_data = top_sh;
        if (shreg[6:0] == ADDR_CTRL) rd_data = {{(WIDTH-2){1'b0}}, ctrl};
    end

    // SPI slave: shift in on rise, shift read data out on fall; cs_n high aborts.
    always_ff @(posedge clk) begin
        if (reset || !cs_active) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            rd_shift <= '0;
            miso     <= 1'b0;
        end else begin
            if (sclk_rise && bit_cnt != CW'(FW)) begin
                shreg   <= {shreg[SW-2:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) begin
                if (bit_cnt == CW'(8)) begin
                    rd_shift <= rd_data;
                    miso     <= rd_data[WIDTH-1];
                end else if (bit_cnt > CW'(8) && bit_cnt < CW'(FW)) begin
                    rd_shift <= {rd_shift[WIDTH-2:0], 1'b0};
                    miso     <= rd_shift[WIDTH-2];
                end else begin
                    miso <= 1'b0;
                end
            end
        end
    end

    // Shared period counter, buffered TOP and immediate control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            top_act      <= TOP_RST;
            top_sh       <= TOP_RST;
            ctrl         <= 2'b01;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            cnt          <= wrap ? '0 : cnt + 1'b1;
            if (wrap) top_act <= top_sh;
            if (wr.en && wr.addr == ADDR_TOP)  top_sh <= wr.data;
            if (wr.en && wr.addr == ADDR_CTRL) ctrl   <= wr.data[1:0];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        spi_pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr.en && wr.addr == 7'(g)),
            .wr_data (wr.data),
            .wrap    (wrap),
            .cnt     (cnt),
            .enable  (ctrl[0]),
            .invert  (ctrl[1]),
            .duty_sh (duty_sh[g]),
            .pwm     (pwm_out[g])
        );
    end
endmodule
